// File: rtl/uart_reg_loader.sv
// UART 8N1 receiver feeding a two-state command parser that issues
// one-cycle register-file strobes (opcode + operand).
module uart_reg_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       rx,
  output logic       reg_ena,
  output logic [2:0] opcode_out,
  output logic [7:0] data_out,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {P_CMD, P_ARG} parse_state_t;

  logic          rx_meta_q, rx_s_q;
  rx_state_t     rx_state_q, rx_state_d;
  parse_state_t  parse_q, parse_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    op_q, op_d;
  logic          reg_ena_q, reg_ena_d;
  logic [2:0]    opcode_q, opcode_d;
  logic [7:0]    data_q, data_d;
  logic          frame_err_q, frame_err_d;
  logic          cmd_err_q, cmd_err_d;
  logic          byte_valid;

  always_comb begin
    rx_state_d  = rx_state_q;
    parse_d     = parse_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    op_d        = op_q;
    opcode_d    = opcode_q;
    data_d      = data_q;
    reg_ena_d   = 1'b0;
    frame_err_d = 1'b0;
    cmd_err_d   = 1'b0;
    byte_valid  = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d      = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d       = '0;
          rx_state_d  = RX_IDLE;
          byte_valid  = rx_s_q;
          frame_err_d = !rx_s_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // LOAD opcodes (000/001) need an operand frame; everything else issues at once.
    if (byte_valid) begin
      if (parse_q == P_ARG) begin
        reg_ena_d = 1'b1;
        opcode_d  = op_q;
        data_d    = shift_q;
        parse_d   = P_CMD;
      end else if (|shift_q[7:3]) begin
        cmd_err_d = 1'b1;
      end else if (shift_q[2:1] == 2'b00) begin
        op_d    = shift_q[2:0];
        parse_d = P_ARG;
      end else begin
        reg_ena_d = 1'b1;
        opcode_d  = shift_q[2:0];
        data_d    = 8'h00;
      end
    end else if (frame_err_d) begin
      parse_d = P_CMD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q  <= RX_IDLE;
      parse_q     <= P_CMD;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      op_q        <= '0;
      reg_ena_q   <= 1'b0;
      opcode_q    <= 3'b111;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else if (ena) begin
      rx_state_q  <= rx_state_d;
      parse_q     <= parse_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      op_q        <= op_d;
      reg_ena_q   <= reg_ena_d;
      opcode_q    <= opcode_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      cmd_err_q   <= cmd_err_d;
    end else begin
      reg_ena_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end
  end

  assign reg_ena    = reg_ena_q & ena;
  assign frame_err  = frame_err_q & ena;
  assign cmd_err    = cmd_err_q & ena;
  assign opcode_out = opcode_q;
  assign data_out   = data_q;
  assign busy       = (rx_state_q != RX_IDLE) || (parse_q == P_ARG);

endmodule

// File: tb/tb_uart_reg_loader.sv
// Directed plus randomized frames for uart_reg_loader, checked against a
// byte-level command model.
module tb_uart_reg_loader;
  localparam int C       = 16;
  localparam int H       = C / 2;
  localparam int FRAME   = 10 * C;
  localparam int GAP     = C;
  // Negedge index (rx falls at index 0) where the strobe becomes visible:
  // 2 sync flops + IDLE detect, H + 9C to the stop sample, 1 register stage.
  localparam int PULSE_K = 3 + H + 9 * C + 1;

  logic       clock = 1'b0;
  logic       reset, ena, rx;
  logic       reg_ena, frame_err, cmd_err, busy;
  logic [2:0] opcode_out;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  bit         m_pending;
  logic [2:0] m_op, m_opcode;
  logic [7:0] m_data;

  uart_reg_loader #(.CLKS_PER_BIT(C)) dut (
    .clock(clock), .reset(reset), .ena(ena), .rx(rx),
    .reg_ena(reg_ena), .opcode_out(opcode_out), .data_out(data_out),
    .frame_err(frame_err), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_op      = 3'b000;
    m_opcode  = 3'b111;
    m_data    = 8'h00;
  endtask

  // Command semantics at byte granularity: what the host expects to see.
  task automatic model_frame(input logic [7:0] b, input bit stop,
                             output bit ei, output bit ef, output bit ec);
    ei = 1'b0; ec = 1'b0; ef = !stop;
    if (!stop) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      ei = 1'b1; m_opcode = m_op; m_data = b; m_pending = 1'b0;
    end else if (b > 8'd7) begin
      ec = 1'b1;
    end else if (b <= 8'd1) begin
      m_pending = 1'b1; m_op = b[2:0];
    end else begin
      ei = 1'b1; m_opcode = b[2:0]; m_data = 8'h00;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input int pause_k, input int reset_k);
    logic [9:0] fr;
    bit ei, ef, ec;
    fr = {stop, b, 1'b0};
    ei = 1'b0; ef = 1'b0; ec = 1'b0;
    if (reset_k < 0) model_frame(b, stop, ei, ef, ec);
    for (int k = 0; k < FRAME + GAP; k++) begin
      @(negedge clock);
      check("reg_ena", {7'b0, reg_ena}, {7'b0, (k == PULSE_K) && ei});
      check("frame_err", {7'b0, frame_err}, {7'b0, (k == PULSE_K) && ef});
      check("cmd_err", {7'b0, cmd_err}, {7'b0, (k == PULSE_K) && ec});
      if (k == PULSE_K && ei) begin
        check("strobe_opcode", {5'b0, opcode_out}, {5'b0, m_opcode});
        check("strobe_data", data_out, m_data);
      end
      if (k == 80) check("busy_mid_frame", {7'b0, busy}, 8'd1);
      if (k == reset_k) begin
        reset = 1'b1; rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check("rst_reg_ena", {7'b0, reg_ena}, 8'd0);
        check("rst_opcode", {5'b0, opcode_out}, {5'b0, m_opcode});
        check("rst_data", data_out, m_data);
        check("rst_busy", {7'b0, busy}, 8'd0);
        return;
      end
      rx = (k < FRAME) ? fr[k / C] : 1'b1;
      if (k == pause_k) begin
        ena = 1'b0;
        repeat (40) begin
          @(negedge clock);
          check("paused_reg_ena", {7'b0, reg_ena}, 8'd0);
        end
        ena = 1'b1;
      end
    end
    check("busy_after_frame", {7'b0, busy}, {7'b0, m_pending});
    check("held_opcode", {5'b0, opcode_out}, {5'b0, m_opcode});
    check("held_data", data_out, m_data);
    $display("frame byte=%02h stop=%0d issue=%0d op=%0d data=%02h", b, stop, ei, opcode_out, data_out);
  endtask

  initial begin
    logic [7:0] rb;
    bit rs;
    int r;

    reset = 1'b1; ena = 1'b1; rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    check("init_reg_ena", {7'b0, reg_ena}, 8'd0);
    check("init_opcode", {5'b0, opcode_out}, 8'd7);
    check("init_data", data_out, 8'd0);
    check("init_frame_err", {7'b0, frame_err}, 8'd0);
    check("init_cmd_err", {7'b0, cmd_err}, 8'd0);
    check("init_busy", {7'b0, busy}, 8'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // LOAD R0, OUT R1, LOAD R1
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hA5, 1'b1, -1, -1);
    send_frame(8'h05, 1'b1, -1, -1);
    send_frame(8'h01, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, -1, -1);

    // Glitch shorter than half a bit
    rx = 1'b0;
    repeat (H - 2) @(negedge clock);
    rx = 1'b1;
    check("glitch_busy_start", {7'b0, busy}, 8'd1);
    for (int i = 0; i < 3 * C; i++) begin
      @(negedge clock);
      check("glitch_reg_ena", {7'b0, reg_ena}, 8'd0);
      check("glitch_frame_err", {7'b0, frame_err}, 8'd0);
    end
    check("glitch_busy_end", {7'b0, busy}, 8'd0);
    $display("glitch done busy=%0d", busy);

    // Framing error cancels a pending LOAD
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'h77, 1'b0, -1, -1);
    send_frame(8'h04, 1'b1, -1, -1);

    // Reserved command bits
    send_frame(8'hF9, 1'b1, -1, -1);

    // Reset mid-DATA of the operand frame, then a clean OUT
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hA5, 1'b1, -1, 4 * C + 5);
    repeat (4) @(negedge clock);
    send_frame(8'h05, 1'b1, -1, -1);

    // Enable pause mid-frame
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'h5A, 1'b1, 4 * C + 2, -1);
    send_frame(8'h06, 1'b1, 2 * C + 2, -1);

    // Randomized command stream
    for (int n = 0; n < 24; n++) begin
      r  = $urandom_range(0, 9);
      rb = (r < 8) ? 8'(r) : 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 7) != 0);
      send_frame(rb, rs, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_reg_loader.md
Name: uart_reg_loader

Overview:
- Serial command front-end for the register file. Receives UART 8N1 bytes on `rx` and parses them into register-file commands.
- Emits a one-cycle write strobe carrying a 3-bit opcode and an 8-bit operand. These drive the register file's `opcode`/`data_in`/`ena` inputs.
- Lets a host load R0/R1, issue MOV, and request OUT without using the ROM.
- Sits between the chip `rx` pin and the register-file input mux.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be an even value of at least 4.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ena  input  1  block enable; when 0, all state holds and no strobes are emitted
- rx  input  1  asynchronous UART serial input, idle high
- reg_ena  output  1  one-cycle strobe: a command is valid on `opcode_out`/`data_out`
- opcode_out  output  3  register-file opcode, held between strobes
- data_out  output  8  operand byte, held between strobes
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- cmd_err  output  1  one-cycle pulse: command byte has nonzero bits [7:3]
- busy  output  1  high while a frame is in progress or the parser awaits an operand

Behaviour:
- **Clock and reset:** single clock domain. Reset is synchronous and active-high.
- **Reset values:** `reg_ena`=0, `opcode_out`=3'b111, `data_out`=0, `frame_err`=0, `cmd_err`=0, `busy`=0. The synchronizer flops reset to 1, the RX FSM to IDLE, the parser to CMD, and the bit counter and sample counter to 0.
- **Reset mid-operation:** a reset during a frame or while in ARG abandons it. No strobe is emitted.
- **Synchronizer:** `rx` passes through a 2-flop synchronizer (`rx_s`). The synchronizer keeps running when `ena`=0.
- **Enable:** when `ena`=0, the FSM, parser and counters freeze, and `reg_ena`/`frame_err`/`cmd_err` are forced to 0.
- **RX FSM:**
  - IDLE: when `rx_s`=0, clear the counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles, sample `rx_s`. If 0, go to DATA. If 1, it was a glitch: return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first, into a shift register. After 8 bits, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`. If 1, raise an internal `byte_valid` for 1 cycle. If 0, pulse `frame_err` and discard the byte. Either way, go to IDLE.
- **Frame timing:** from the cycle START is entered to the stop sample is CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles. IDLE can detect the next start bit on the cycle after the stop sample.
- **Parser states:** CMD and ARG.
  - **CMD, on `byte_valid`:**
    - If bits [7:3] are nonzero, pulse `cmd_err`, drop the byte and stay in CMD.
    - If bits [2:0] are 000 or 001 (LOAD), latch the opcode and go to ARG.
    - Otherwise (MOV/OUT/NOP), issue the command with `data_out`=0.
  - **ARG, on `byte_valid`:** the byte is the operand, with no reserved-bit check. Issue the command with the latched opcode and `data_out`=byte, then return to CMD.
  - **ARG, on `frame_err`:** drop the pending LOAD and return to CMD. No strobe is emitted.
- **Issue:** on the cycle after `byte_valid`, `reg_ena`=1 for exactly 1 cycle. `opcode_out` and `data_out` update in that same cycle and are held until the next issue.
- **Strobe rate:** at most one strobe per frame, so strobes are never back-to-back.
- **`busy`:** equals (RX FSM != IDLE) OR (parser == ARG).

Test Plan:
- LOAD R0: send frames 0x00 then 0xA5 -> one `reg_ena` pulse, `opcode_out`=000, `data_out`=0xA5, asserted 1 cycle after the second stop sample. No pulse after the first byte. `busy` stays high between the two frames.
- OUT R1: send 0x05 -> `reg_ena` pulse, `opcode_out`=101, `data_out`=0x00. A following LOAD R1 (0x01, 0x3C) -> pulse with 001/0x3C.
- Glitch rejection: drive `rx` low for CLKS_PER_BIT/2-2 cycles, then high -> no `reg_ena`, no `frame_err`, `busy` returns to 0.
- Framing error: send 0x00, then a byte 0x77 with stop bit = 0 -> `frame_err` pulse, no `reg_ena`, parser back in CMD. A subsequent 0x04 -> pulse with `opcode_out`=100.
- Reserved bits: send 0xF9 -> `cmd_err` pulse, no `reg_ena`, `opcode_out` unchanged.
- Reset and enable: assert `reset` mid-DATA of the operand frame after 0x00 -> all outputs return to reset values, and a later clean 0x05 produces a normal strobe. Deassert `ena` for 40 cycles mid-frame, then resume -> the byte is still received correctly, with the strobe delayed by 40 cycles.
